// File: rtl/encoder_pkg.sv
// encoder_pkg: shared state type, index constants and index-to-mask helper
package encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [1:0] IDX_D0 = 2'd0;
    localparam logic [1:0] IDX_D1 = 2'd1;
    localparam logic [1:0] IDX_D2 = 2'd2;
    localparam logic [1:0] IDX_D3 = 2'd3;

    function automatic logic [3:0] onehot2(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/encoder_4_to_2_seq_priority_enc.sv
// priority_enc_4to2: combinational 4-to-2 priority encoder with any/multi flags
module priority_enc_4to2
    import encoder_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic [3:0] in,
    output logic [1:0] idx,
    output logic       any,
    output logic       multi
);

    always_comb begin
        idx   = HIGH_FIRST ? (in[3] ? IDX_D3 : in[2] ? IDX_D2 : in[1] ? IDX_D1 : IDX_D0)
                           : (in[0] ? IDX_D0 : in[1] ? IDX_D1 : in[2] ? IDX_D2 : IDX_D3);
        any   = |in;
        // clearing the lowest set bit leaves something only if two or more were set
        multi = |(in & (in - 4'd1));
    end

endmodule

// File: rtl/encoder_4_to_2_seq.sv
// encoder_4_to_2_seq: registered priority encoder with request latching and valid/ACK handshake
module encoder_4_to_2_seq
    import encoder_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1,
    parameter bit STICKY     = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic ACK,
    output logic A0,
    output logic A1,
    output logic V,
    output logic MULTI
);

    state_t     state;
    logic [3:0] pend;
    logic [3:0] clr;
    logic [3:0] rem;
    logic [3:0] src;
    logic [3:0] pend_nxt;
    logic [1:0] idx;
    logic       any;
    logic       multi;
    logic       serve;

    always_comb begin
        clr      = (V && ACK) ? onehot2({A1, A0}) : 4'b0;
        rem      = pend & ~clr;
        src      = (state == IDLE) ? pend : rem;
        serve    = (state == IDLE) || ACK;
        // new captures join after the reload choice, so a same-cycle re-request waits its turn
        pend_nxt = (STICKY ? rem : 4'b0) | (EN ? {D3, D2, D1, D0} : 4'b0);
    end

    priority_enc_4to2 #(.HIGH_FIRST(HIGH_FIRST)) u_penc (
        .in   (src),
        .idx  (idx),
        .any  (any),
        .multi(multi)
    );

    assign V = (state == HOLD);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend     <= 4'b0;
            state    <= IDLE;
            {A1, A0} <= IDX_D0;
            MULTI    <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (serve) begin
                state <= any ? HOLD : IDLE;
                if (any) begin
                    {A1, A0} <= idx;
                    MULTI    <= multi;
                end
            end
        end
    end

endmodule

// File: tb/tb_encoder_4_to_2_seq.sv
// tb_encoder_4_to_2_seq: directed and randomized checks against a behavioural request-queue model
module tb_encoder_4_to_2_seq;

    localparam bit HIGH_FIRST = 1'b1;
    localparam bit STICKY     = 1'b1;

    logic CLK = 1'b0;
    logic RST, EN, D0, D1, D2, D3, ACK;
    logic A0, A1, V, MULTI;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] mp;
    logic       mv, mm;
    logic [1:0] ma;

    encoder_4_to_2_seq #(.HIGH_FIRST(HIGH_FIRST), .STICKY(STICKY)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .D0   (D0),
        .D1   (D1),
        .D2   (D2),
        .D3   (D3),
        .ACK  (ACK),
        .A0   (A0),
        .A1   (A1),
        .V    (V),
        .MULTI(MULTI)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] win(input logic [3:0] p);
        for (int i = 0; i < 4; i++) begin
            int b;
            b = HIGH_FIRST ? 3 - i : i;
            if (p[b]) return 2'(b);
        end
        return 2'd0;
    endfunction

    always @(posedge CLK or posedge RST) begin : model
        logic [3:0] clr, rem;
        if (RST) begin
            mp <= 4'b0; mv <= 1'b0; mm <= 1'b0; ma <= 2'd0;
        end else begin
            clr = (mv && ACK) ? 4'(1 << ma) : 4'b0;
            rem = mp & ~clr;
            if (!mv && mp != 0) begin
                ma <= win(mp); mm <= $countones(mp) > 1; mv <= 1'b1;
            end else if (mv && ACK) begin
                if (rem != 0) begin
                    ma <= win(rem); mm <= $countones(rem) > 1;
                end else mv <= 1'b0;
            end
            mp <= (STICKY ? rem : 4'b0) | (EN ? {D3, D2, D1, D0} : 4'b0);
        end
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".v"}, {3'b0, V}, {3'b0, mv});
        check({tag, ".idx"}, {2'b0, A1, A0}, {2'b0, ma});
        check({tag, ".multi"}, {3'b0, MULTI}, {3'b0, mm});
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] a, input logic m);
        check({tag, ".v"}, {3'b0, V}, {3'b0, v});
        if (v) check({tag, ".idx"}, {2'b0, A1, A0}, {2'b0, a});
        if (v) check({tag, ".multi"}, {3'b0, MULTI}, {3'b0, m});
    endtask

    task automatic set_d(input logic [3:0] d);
        {D3, D2, D1, D0} = d;
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        @(negedge CLK);
        check_model(tag);
    endtask

    initial begin
        RST = 1'b1; EN = 1'b1; ACK = 1'b0; set_d(4'b1111);
        #2;
        check_out("reset_async", 1'b0, 2'd0, 1'b0);
        check({"reset_async", ".idx"}, {2'b0, A1, A0}, 4'b0);
        check({"reset_async", ".multi"}, {3'b0, MULTI}, 4'b0);
        @(negedge CLK);
        tick("reset_held");
        check_out("reset_held", 1'b0, 2'd0, 1'b0);
        RST = 1'b0; set_d(4'b0000);
        tick("post_reset");

        set_d(4'b0100);
        tick("single_k");
        check_out("single_k", 1'b0, 2'd0, 1'b0);
        set_d(4'b0000);
        tick("single_k1");
        check_out("single_k1", 1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick("single_hold");
            check_out("single_hold", 1'b1, 2'd2, 1'b0);
        end
        ACK = 1'b1;
        tick("single_ack");
        check_out("single_ack", 1'b0, 2'd0, 1'b0);

        set_d(4'b1011);
        tick("multi_cap");
        set_d(4'b0000);
        tick("multi_0");
        check_out("multi_0", 1'b1, 2'd3, 1'b1);
        tick("multi_1");
        check_out("multi_1", 1'b1, 2'd1, 1'b1);
        tick("multi_2");
        check_out("multi_2", 1'b1, 2'd0, 1'b0);
        tick("multi_end");
        check_out("multi_end", 1'b0, 2'd0, 1'b0);
        ACK = 1'b0;

        set_d(4'b0100);
        tick("setwin_cap");
        set_d(4'b0000);
        tick("setwin_v");
        check_out("setwin_v", 1'b1, 2'd2, 1'b0);
        ACK = 1'b1; set_d(4'b0100);
        tick("setwin_ack");
        ACK = 1'b0; set_d(4'b0000);
        tick("setwin_again");
        check_out("setwin_again", 1'b1, 2'd2, 1'b0);
        ACK = 1'b1;
        tick("setwin_done");
        check_out("setwin_done", 1'b0, 2'd0, 1'b0);
        ACK = 1'b0;

        EN = 1'b0; set_d(4'b1111);
        for (int i = 0; i < 3; i++) begin
            tick("en_off");
            check_out("en_off", 1'b0, 2'd0, 1'b0);
        end
        EN = 1'b1;
        tick("en_cap");
        EN = 1'b0; ACK = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            tick("en_serve");
            check_out("en_serve", 1'b1, 2'(i), i != 0);
        end
        tick("en_end");
        check_out("en_end", 1'b0, 2'd0, 1'b0);
        ACK = 1'b0; EN = 1'b1;

        set_d(4'b0110);
        tick("midrst_cap");
        set_d(4'b0000);
        tick("midrst_v");
        check_out("midrst_v", 1'b1, 2'd2, 1'b1);
        #2 RST = 1'b1;
        #1;
        check_out("midrst_now", 1'b0, 2'd0, 1'b0);
        check({"midrst_now", ".idx"}, {2'b0, A1, A0}, 4'b0);
        #1 RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("midrst_after");
            check_out("midrst_after", 1'b0, 2'd0, 1'b0);
        end

        for (int i = 0; i < 400; i++) begin
            EN  = ($urandom_range(0, 3) != 0);
            ACK = ($urandom_range(0, 2) != 0);
            set_d(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
            if ($urandom_range(0, 150) == 0) begin
                #2 RST = 1'b1;
                #1 RST = 1'b0;
            end
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
